// File: rtl/jtframe_coin_sched.sv
// Frame-timed coin pulse scheduler: queues per-player coin presses and replays them one at a
// time as fixed-width pulses with round-robin arbitration. Define JTFRAME_COIN_LOCKOUT_EN for coin_lockout.
module jtframe_coin_sched #(
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int PULSE_FRAMES = 3,
    parameter int GAP_FRAMES   = 3,
    parameter int MAX_PEND     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vs,
    input  logic       lock,
    input  logic [3:0] coin_in,
`ifdef JTFRAME_COIN_LOCKOUT_EN
    input  logic [3:0] coin_lockout,
`endif
    output logic [3:0] coin_out,
    output logic       busy,
    output logic       drop
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] PULSE_LAST = 4'(PULSE_FRAMES - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_FRAMES - 1);
    localparam logic [1:0] PEND_MAX   = 2'(MAX_PEND);
    localparam logic [3:0] INACTIVE   = {4{ACTIVE_LOW}};
    localparam bit         HAS_GAP    = (GAP_FRAMES != 0);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [1:0] pend    [4];
    logic [1:0] pend_nx [4];
    logic [1:0] rr_ptr, rr_nx;
    logic [3:0] coin_l;
    logic       vs_l;
    logic [3:0] coin_nx;
    logic       busy_nx, drop_nx;

    logic [3:0] req, lockout, dec;
    logic       tick;
    logic       grant_vld;
    logic [1:0] grant;

    assign req  = coin_in & ~coin_l;
    assign tick = vs & ~vs_l;

`ifdef JTFRAME_COIN_LOCKOUT_EN
    assign lockout = coin_lockout;
`else
    assign lockout = 4'b0000;
`endif

    // Round-robin search from rr_ptr; scanning backwards lets the nearest candidate win.
    always_comb begin
        grant_vld = 1'b0;
        grant     = rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (pend[rr_ptr + 2'(i)] != 2'd0) begin
                grant_vld = 1'b1;
                grant     = rr_ptr + 2'(i);
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets its default first so no path can leave it unassigned (no latches).
        state_nx = state;
        cnt_nx   = cnt;
        rr_nx    = rr_ptr;
        coin_nx  = coin_out;
        drop_nx  = 1'b0;
        dec      = 4'b0000;

        unique case (state)
            IDLE: begin
                if (grant_vld) begin
                    dec[grant] = 1'b1;
                    rr_nx      = grant + 2'd1;
                    coin_nx    = INACTIVE ^ (4'b0001 << grant);
                    cnt_nx     = 4'd0;
                    state_nx   = PULSE;
                end
            end
            PULSE: begin
                if (tick) begin
                    if (cnt == PULSE_LAST) begin
                        cnt_nx   = 4'd0;
                        coin_nx  = INACTIVE;
                        state_nx = HAS_GAP ? GAP : IDLE;
                    end else begin
                        cnt_nx = cnt + 4'd1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (cnt == GAP_LAST) begin
                        cnt_nx   = 4'd0;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt + 4'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // Grant is taken before the new request so a full queue granted and pressed stays full.
        for (int i = 0; i < 4; i++) begin
            pend_nx[i] = pend[i] - {1'b0, dec[i]};
            if (req[i]) begin
                if (lockout[i]) begin
                    drop_nx = 1'b1;
                end else if (pend_nx[i] < PEND_MAX) begin
                    pend_nx[i] = pend_nx[i] + 2'd1;
                end else begin
                    drop_nx = 1'b1;
                end
            end
        end

        if (lock) begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
            coin_nx  = INACTIVE;
            drop_nx  = 1'b0;
            rr_nx    = rr_ptr;
            for (int i = 0; i < 4; i++) pend_nx[i] = 2'd0;
        end

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rr_ptr   <= 2'd0;
            coin_out <= INACTIVE;
            busy     <= 1'b0;
            drop     <= 1'b0;
            coin_l   <= 4'hF;
            vs_l     <= 1'b1;
            // NOTE: the pending counters are state, not storage, so they are reset like any flop.
            for (int i = 0; i < 4; i++) pend[i] <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state    <= state_nx;
            cnt      <= cnt_nx;
            rr_ptr   <= rr_nx;
            coin_out <= coin_nx;
            busy     <= busy_nx;
            drop     <= drop_nx;
            coin_l   <= coin_in;
            vs_l     <= vs;
            for (int i = 0; i < 4; i++) pend[i] <= pend_nx[i];
        end
    end

    a_one_coin : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(coin_out ^ INACTIVE));

endmodule

// File: tb/tb_jtframe_coin_sched.sv
// Self-checking bench for jtframe_coin_sched: a job-level model (pending counts plus remaining
// pulse/gap ticks) is compared every cycle, with directed scenarios pinned by literal values.
module tb_jtframe_coin_sched;

    localparam int       PULSE   = 3;
    localparam int       GAPF    = 3;
    localparam int       MAXP    = 3;
    localparam int       FRAME   = 8;
    localparam bit       ACT_LOW = 1'b1;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       vs      = 1'b0;
    logic       lock    = 1'b0;
    logic [3:0] coin_in = 4'b0000;
`ifdef JTFRAME_COIN_LOCKOUT_EN
    logic [3:0] coin_lockout = 4'b0000;
`endif
    logic [3:0] coin_out;
    logic       busy;
    logic       drop;

    int checks   = 0;
    int failures = 0;

    // Model state: what is owed to each player and how much of the current job is left.
    int         m_pend [4];
    int         m_rr;
    int         m_who;
    int         m_pulse_left;
    int         m_gap_left;
    logic [3:0] m_prev_coin;
    logic       m_prev_vs;
    logic       m_drop;
    logic       m_tick;
    int         fcnt = 0;
    bit         cmp_en = 1'b0;

    always #5 clk = ~clk;

    jtframe_coin_sched #(
        .ACTIVE_LOW  (ACT_LOW),
        .PULSE_FRAMES(PULSE),
        .GAP_FRAMES  (GAPF),
        .MAX_PEND    (MAXP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vs          (vs),
        .lock        (lock),
        .coin_in     (coin_in),
`ifdef JTFRAME_COIN_LOCKOUT_EN
        .coin_lockout(coin_lockout),
`endif
        .coin_out    (coin_out),
        .busy        (busy),
        .drop        (drop)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pend[i] = 0;
        m_rr         = 0;
        m_who        = 0;
        m_pulse_left = 0;
        m_gap_left   = 0;
        m_prev_coin  = 4'hF;
        m_prev_vs    = 1'b1;
        m_drop       = 1'b0;
        m_tick       = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] r;
        logic [3:0] lo;
        r           = coin_in & ~m_prev_coin;
        m_tick      = vs & ~m_prev_vs;
        m_prev_coin = coin_in;
        m_prev_vs   = vs;
        m_drop      = 1'b0;
`ifdef JTFRAME_COIN_LOCKOUT_EN
        lo = coin_lockout;
`else
        lo = 4'b0000;
`endif
        if (lock) begin
            for (int i = 0; i < 4; i++) m_pend[i] = 0;
            m_pulse_left = 0;
            m_gap_left   = 0;
        end else begin
            if (m_pulse_left == 0 && m_gap_left == 0) begin
                for (int k = 0; k < 4; k++) begin
                    int p;
                    p = (m_rr + k) % 4;
                    if (m_pend[p] > 0) begin
                        m_pend[p]--;
                        m_who        = p;
                        m_rr         = (p + 1) % 4;
                        m_pulse_left = PULSE;
                        m_gap_left   = GAPF;
                        break;
                    end
                end
            end else if (m_pulse_left > 0) begin
                if (m_tick) m_pulse_left--;
            end else if (m_tick) begin
                m_gap_left--;
            end
            for (int i = 0; i < 4; i++) begin
                if (r[i]) begin
                    if (lo[i]) m_drop = 1'b1;
                    else if (m_pend[i] < MAXP) m_pend[i]++;
                    else m_drop = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [3:0] exp_coin();
        logic [3:0] a;
        a = (m_pulse_left > 0) ? (4'b0001 << m_who) : 4'b0000;
        return a ^ {4{ACT_LOW}};
    endfunction

    function automatic int pend_sum();
        return m_pend[0] + m_pend[1] + m_pend[2] + m_pend[3];
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_coin_out", coin_out, exp_coin());
            check("cyc_busy", busy, (m_pulse_left > 0 || m_gap_left > 0));
            check("cyc_drop", drop, m_drop);
        end
    end

    // One clock: model follows the edge, inputs for the next edge change after the negedge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        fcnt++;
        vs = (fcnt % FRAME) < 2;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic press(input logic [3:0] m);
        coin_in = coin_in | m;
        cycle();
        coin_in = coin_in & ~m;
        cycle();
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((busy || pend_sum() != 0) && n < 3000) begin
            cycle();
            n++;
        end
        check(name, (n < 3000), 1);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        run(2);
        check("rst_coin_out", coin_out, 4'hF);
        check("rst_busy", busy, 0);
        #2 rst_n = 1'b1;
        run(1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, tk, np;
        logic [3:0] prev;

        #1 rst_n = 1'b0;
        model_reset();
        cmp_en = 1'b1;
        run(3);
        check("init_coin_out", coin_out, 4'hF);
        check("init_busy", busy, 0);
        check("init_drop", drop, 0);
        #2 rst_n = 1'b1;
        run(2);

        // Single P1 press: 3 ticks active, 3 ticks gap.
        press(4'b0001);
        check("t1_grant", coin_out, 4'b1110);
        check("t1_busy", busy, 1);
        tk = 0; n = 0;
        while (coin_out != 4'hF && n < 300) begin cycle(); tk += int'(m_tick); n++; end
        check("t1_pulse_ticks", tk, 3);
        tk = 0; n = 0;
        while (busy && n < 300) begin cycle(); tk += int'(m_tick); n++; end
        check("t1_gap_ticks", tk, 3);
        check("t1_end_coin", coin_out, 4'hF);

        // P1 and P3 together from rr_ptr=0, then P1+P4 proves rr_ptr landed on 3.
        do_reset();
        press(4'b0101);
        check("t2_first_p1", coin_out, 4'b1110);
        n = 0;
        while (coin_out == 4'b1110 && n < 300) begin cycle(); n++; end
        while (coin_out == 4'hF && n < 300) begin cycle(); n++; end
        check("t2_second_p3", coin_out, 4'b1011);
        wait_quiet("t2_quiet_a");
        press(4'b1001);
        check("t2_rr_p4_first", coin_out, 4'b0111);
        wait_quiet("t2_quiet_b");

        // Four P2 presses while P1 busy: the fourth drops; a press at grant time keeps it full.
        press(4'b0001);
        check("t3_p1_active", coin_out, 4'b1110);
        repeat (3) press(4'b0010);
        coin_in = 4'b0010;
        cycle();
        check("t3_drop_strobe", drop, 1);
        coin_in = 4'b0000;
        cycle();
        check("t3_drop_cleared", drop, 0);
        check("t3_model_pend", m_pend[1], 3);
        n = 0;
        while (busy && n < 300) begin cycle(); n++; end
        check("t3_idle_before_grant", busy, 0);
        coin_in = 4'b0010;
        cycle();
        coin_in = 4'b0000;
        check("t3_grant_req_no_drop", drop, 0);
        check("t3_p2_active", coin_out, 4'b1101);
        check("t3_model_pend_full", m_pend[1], 3);
        np = 1; prev = coin_out; n = 0;
        while ((busy || m_pend[1] != 0) && n < 3000) begin
            cycle();
            if (prev == 4'hF && coin_out == 4'b1101) np++;
            prev = coin_out;
            n++;
        end
        check("t3_p2_pulses", np, 4);

        // lock mid-pulse with two P3 coins queued.
        press(4'b0001);
        press(4'b0100);
        press(4'b0100);
        check("t4_model_pend3", m_pend[2], 2);
        check("t4_p1_active", coin_out, 4'b1110);
        lock = 1'b1;
        coin_in = 4'b0100;
        cycle();
        check("t4_lock_coin", coin_out, 4'hF);
        check("t4_lock_busy", busy, 0);
        check("t4_lock_drop", drop, 0);
        coin_in = 4'b0000;
        run(2);
        lock = 1'b0;
        run(10);
        check("t4_after_lock_coin", coin_out, 4'hF);
        check("t4_after_lock_busy", busy, 0);
        press(4'b0010);
        check("t4_resume_p2", coin_out, 4'b1101);
        wait_quiet("t4_quiet");

        // Reset mid-gap with coin_in[0] held across release.
        coin_in = 4'b0001;
        run(2);
        check("t5_grant", coin_out, 4'b1110);
        n = 0;
        while (coin_out != 4'hF && n < 300) begin cycle(); n++; end
        check("t5_in_gap", busy, 1);
        do_reset();
        run(30);
        check("t5_held_no_pulse", coin_out, 4'hF);
        check("t5_held_busy", busy, 0);
        coin_in = 4'b0000;
        cycle();
        coin_in = 4'b0001;
        run(2);
        check("t5_repress", coin_out, 4'b1110);
        coin_in = 4'b0000;
        wait_quiet("t5_quiet");

`ifdef JTFRAME_COIN_LOCKOUT_EN
        coin_lockout = 4'b0001;
        coin_in = 4'b0001;
        cycle();
        check("t6_lockout_drop", drop, 1);
        coin_in = 4'b0000;
        run(5);
        check("t6_lockout_coin", coin_out, 4'hF);
        press(4'b0010);
        check("t6_p2_pulse", coin_out, 4'b1101);
        coin_lockout = 4'b0000;
        wait_quiet("t6_quiet");
`endif

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
